// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: data width, operation
// encodings (RV64M funct3), FSM state encoding and small decode helpers.
package muldiv_unit_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned CntW = 7;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic is_div(op_e op);
        return op inside {OpDiv, OpDivu, OpRem, OpRemu};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue logic and the multiply/divide unit.
//   master: drives start/op/index_rd_in/data_rs1/data_rs2/flush, sees status and
//           the register-file write port.
//   slave : the unit itself.
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic            start;
    logic [2:0]      op;
    logic [4:0]      index_rd_in;
    logic [XLEN-1:0] data_rs1;
    logic [XLEN-1:0] data_rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic            wen;
    logic [4:0]      index_rd;
    logic [XLEN-1:0] data_rd;

    modport master (
        output start, op, index_rd_in, data_rs1, data_rs2, flush,
        input  busy, done, wen, index_rd, data_rd
    );

    modport slave (
        input  start, op, index_rd_in, data_rs1, data_rs2, flush,
        output busy, done, wen, index_rd, data_rd
    );

endinterface

// File: rtl/muldiv_iter.sv
// One radix-2 step per cycle on unsigned magnitudes.
//   load_i   : capture a_i into the accumulator, b_i as multiplicand/divisor,
//              clear the step counter.
//   step_i   : advance one shift-add (multiply) or restoring (divide) step.
//   acc_nxt_o: accumulator value after the step taken this cycle.
//              Multiply: {hi, lo} product. Divide: {remainder, quotient}.
//   cnt_o    : number of steps taken since load.
module muldiv_iter
    import muldiv_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                load_i,
    input  logic                step_i,
    input  logic                is_div_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [2*XLEN-1:0]   acc_nxt_o,
    output logic [CntW-1:0]     cnt_o
);
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   b_q;
    logic              div_q;
    logic [CntW-1:0]   cnt_q;

    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] step_mul;
    logic [2*XLEN-1:0] step_div;

    always_comb begin
        // Multiply: add b into the upper half when the lsb is set, then shift right
        // with the carry entering at the top.
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        step_mul = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        // Divide: the shifted partial remainder needs 65 bits before the compare.
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, b_q};
        step_div = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        acc_nxt_o = div_q ? step_div : step_mul;
    end

    assign cnt_o = cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= {{XLEN{1'b0}}, a_i};
            b_q   <= b_i;
            div_q <= is_div_i;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_nxt_o;
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit with direct register-file write port.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : slave side of muldiv_unit_if (start/op/operands/flush in,
//               busy/done/wen/index_rd/data_rd out, all outputs registered)
// Operands are converted to magnitudes on start, iterated 64 cycles in
// muldiv_iter, and sign-fixed when entering DONE. Divide-by-zero and signed
// overflow skip CALC and finish the cycle after start.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input logic          clk,
    input logic          rstn,
    muldiv_unit_if.slave bus
);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q;
    op_e             op_q;
    logic [4:0]      rd_q;
    logic            neg_q;
    logic            busy_q;
    logic            done_q;
    logic            wen_q;
    logic [4:0]      index_rd_q;
    logic [XLEN-1:0] data_rd_q;

    op_e               op_in;
    logic              signed_a, signed_b, a_neg, b_neg, neg_in;
    logic              div_zero, div_ovf, accept, step;
    logic [XLEN-1:0]   mag_a, mag_b, special_res, calc_res;
    logic [2*XLEN-1:0] acc_nxt, prod;
    logic [CntW-1:0]   cnt;

    always_comb begin
        op_in    = op_e'(bus.op);
        signed_a = op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem};
        signed_b = op_in inside {OpMulh, OpDiv, OpRem};
        a_neg    = signed_a & bus.data_rs1[XLEN-1];
        b_neg    = signed_b & bus.data_rs2[XLEN-1];
        mag_a    = a_neg ? -bus.data_rs1 : bus.data_rs1;
        mag_b    = b_neg ? -bus.data_rs2 : bus.data_rs2;
        // Remainder takes the dividend's sign; everything else the xor.
        neg_in   = (op_in inside {OpRem, OpRemu}) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div(op_in) && (bus.data_rs2 == '0);
        div_ovf  = (op_in inside {OpDiv, OpRem}) && (bus.data_rs1 == MinNeg)
                   && (bus.data_rs2 == '1);
        if (div_zero) begin
            special_res = (op_in inside {OpDiv, OpDivu}) ? '1 : bus.data_rs1;
        end else begin
            special_res = (op_in == OpDiv) ? bus.data_rs1 : '0;
        end
        // Flush outranks a start presented in the same cycle.
        accept = (state_q == StIdle) && bus.start && !bus.flush;
        step   = (state_q == StCalc) && !bus.flush;
    end

    always_comb begin
        prod     = neg_q ? -acc_nxt : acc_nxt;
        calc_res = '0;
        case (op_q)
            OpMul:                      calc_res = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu:  calc_res = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:              calc_res = neg_q ? -acc_nxt[XLEN-1:0]
                                                         : acc_nxt[XLEN-1:0];
            default:                    calc_res = neg_q ? -acc_nxt[2*XLEN-1:XLEN]
                                                         : acc_nxt[2*XLEN-1:XLEN];
        endcase
    end

    muldiv_iter u_iter (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (accept),
        .step_i    (step),
        .is_div_i  (is_div(op_in)),
        .a_i       (mag_a),
        .b_i       (mag_b),
        .acc_nxt_o (acc_nxt),
        .cnt_o     (cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            op_q       <= OpMul;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wen_q      <= 1'b0;
            index_rd_q <= '0;
            data_rd_q  <= '0;
        end else begin
            done_q <= 1'b0;
            wen_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q   <= op_in;
                        rd_q   <= bus.index_rd_in;
                        neg_q  <= neg_in;
                        busy_q <= 1'b1;
                        if (div_zero || div_ovf) begin
                            state_q    <= StDone;
                            done_q     <= 1'b1;
                            wen_q      <= (bus.index_rd_in != '0);
                            index_rd_q <= bus.index_rd_in;
                            data_rd_q  <= special_res;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (cnt == CntW'(63)) begin
                        state_q    <= StDone;
                        done_q     <= 1'b1;
                        wen_q      <= (rd_q != '0);
                        index_rd_q <= rd_q;
                        data_rd_q  <= calc_res;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wen      = wen_q;
    assign bus.index_rd = index_rd_q;
    assign bus.data_rd  = data_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;
    localparam logic [63:0] AllOne = 64'hFFFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 128-bit arithmetic and language division.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] p;
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
            3'd4: begin
                if (b == 0) return AllOne;
                if (a == MinNeg && b == AllOne) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? AllOne : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MinNeg && b == AllOne) return 64'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [63:0] a,
                                       input logic [63:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MinNeg && b == AllOne) return 1;
        return 65;
    endfunction

    task automatic watch_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.done || bus.wen) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    // Issue one operation, scramble inputs afterwards, optionally re-pulse start
    // at CALC cycle pulse_at, and check the DONE cycle plus the cycle after.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input int pulse_at, output logic [63:0] got);
        int n;
        logic [63:0] exp;
        exp = ref_result(op, a, b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.data_rs1 = a;
        bus.data_rs2 = b;
        bus.index_rd_in = rd;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 3'($urandom);
        bus.data_rs1 = {$urandom, $urandom};
        bus.data_rs2 = {$urandom, $urandom};
        bus.index_rd_in = 5'($urandom);
        n = 1;
        while (!bus.done && n < 100) begin
            if (n == pulse_at) begin
                bus.start = 1'b1;
                bus.op = 3'd5;
                bus.data_rs2 = 64'd0;
            end
            if (n == pulse_at + 1) bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(ref_latency(op, a, b)));
        check("done", 64'(bus.done), 64'd1);
        check("busy_in_done", 64'(bus.busy), 64'd1);
        check("wen", 64'(bus.wen), 64'(rd != 0));
        check("index_rd", 64'(bus.index_rd), 64'(rd));
        check("data_rd", bus.data_rd, exp);
        got = bus.data_rd;
        @(negedge clk);
        check("done_after", 64'(bus.done), 64'd0);
        check("wen_after", 64'(bus.wen), 64'd0);
        check("busy_after", 64'(bus.busy), 64'd0);
        check("data_hold", bus.data_rd, exp);
        check("index_hold", 64'(bus.index_rd), 64'(rd));
    endtask

    initial begin
        logic [63:0] got, a, b;
        logic [2:0]  op;
        int          k;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op = 3'd0;
        bus.data_rs1 = '0;
        bus.data_rs2 = '0;
        bus.index_rd_in = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_wen", 64'(bus.wen), 64'd0);
        check("rst_index_rd", 64'(bus.index_rd), 64'd0);
        check("rst_data_rd", bus.data_rd, 64'd0);
        rstn = 1'b1;

        run_op(3'd0, 64'd7, -64'd3, 5'd5, 0, got);
        check("mul_7x-3", got, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'd3, AllOne, AllOne, 5'd1, 0, got);
        check("mulhu_ones", got, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(3'd1, AllOne, AllOne, 5'd2, 0, got);
        check("mulh_ones", got, 64'd0);
        run_op(3'd4, -64'd7, 64'd2, 5'd3, 0, got);
        check("div_-7/2", got, -64'd3);
        run_op(3'd6, -64'd7, 64'd2, 5'd4, 0, got);
        check("rem_-7/2", got, AllOne);
        run_op(3'd5, 64'd9, 64'd0, 5'd6, 0, got);
        check("divu_by0", got, AllOne);
        run_op(3'd7, 64'd9, 64'd0, 5'd7, 0, got);
        check("remu_by0", got, 64'd9);
        run_op(3'd4, MinNeg, AllOne, 5'd8, 0, got);
        check("div_ovf", got, MinNeg);
        run_op(3'd6, MinNeg, AllOne, 5'd9, 0, got);
        check("rem_ovf", got, 64'd0);
        run_op(3'd0, 64'd3, 64'd4, 5'd0, 0, got);
        check("mul_rd0", got, 64'd12);

        // Start re-pulsed during CALC must be ignored.
        run_op(3'd2, -64'd5, 64'd1000, 5'd10, 10, got);
        watch_quiet("repulse_single_done", 70);

        // Flush at CALC cycle 30.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'd0;
        bus.data_rs1 = 64'd11;
        bus.data_rs2 = 64'd13;
        bus.index_rd_in = 5'd12;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        while (k < 30) begin @(negedge clk); k++; end
        check("busy_calc", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_done", 64'(bus.done), 64'd0);
        watch_quiet("flush_no_done", 70);

        // Known nonzero outputs before the reset test.
        run_op(3'd5, 64'd100, 64'd7, 5'd13, 0, got);

        // Reset at CALC cycle 40.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'd4;
        bus.data_rs1 = 64'd1234;
        bus.data_rs2 = 64'd5;
        bus.index_rd_in = 5'd14;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        while (k < 40) begin @(negedge clk); k++; end
        rstn = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_wen", 64'(bus.wen), 64'd0);
        check("arst_index_rd", 64'(bus.index_rd), 64'd0);
        check("arst_data_rd", bus.data_rd, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        watch_quiet("arst_no_wen", 70);

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: b = 64'd0;
                1: begin a = MinNeg; b = AllOne; end
                2: b = 64'($urandom_range(1, 15));
                3: a = 64'($urandom_range(0, 300));
                default: ;
            endcase
            run_op(op, a, b, 5'($urandom), 0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
